// File: rtl/qam_sym_mapper_pkg.sv
// Shared types and helpers for the QAM symbol mapper.
package qam_sym_mapper_pkg;

  // Depth of the bit buffer between the byte input and the symbol extractor.
  localparam int unsigned SYM_BUF_BITS = 14;

  typedef enum logic [1:0] {
    QPSK  = 2'd0,
    QAM16 = 2'd1,
    QAM64 = 2'd2
  } qam_mode_t;

  // Bits consumed per symbol (k).
  function automatic logic [3:0] bits_per_sym(input qam_mode_t m);
    logic [3:0] k;
    case (m)
      QPSK:    k = 4'd2;
      QAM64:   k = 4'd6;
      default: k = 4'd4;
    endcase
    return k;
  endfunction

  // Map the raw mode input onto a supported mode; code 3 and unsupported 64-QAM fall to 16-QAM.
  function automatic qam_mode_t decode_mode(input logic [1:0] m, input logic allow_64);
    qam_mode_t r;
    case (m)
      2'd0:    r = QPSK;
      2'd2:    r = allow_64 ? QAM64 : QAM16;
      default: r = QAM16;
    endcase
    return r;
  endfunction

  // Gray-to-binary for up to 3 bits; leading zeros leave narrower fields unchanged.
  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/qam_level_map.sv
// Combinational axis-level mapper: top-aligned 6-bit field -> signed odd-integer I/Q levels.
// QAM_GRAY_EN selects Gray-decoded axis fields; default is natural binary.
module qam_level_map
  import qam_sym_mapper_pkg::*;
(
  input  logic [5:0]        field_i,
  input  qam_mode_t         mode_i,
  output logic signed [3:0] lvl_i_o,
  output logic signed [3:0] lvl_q_o
);

  logic [2:0]        raw_i, raw_q;
  logic [2:0]        n_i, n_q;
  logic [3:0]        ofs;
  logic signed [4:0] full_i, full_q;

  // Split the field into the I (first half) and Q (second half) axis bits.
  always_comb begin
    raw_i = '0;
    raw_q = '0;
    ofs   = 4'd3;
    case (mode_i)
      QPSK: begin
        raw_i = {2'b00, field_i[5]};
        raw_q = {2'b00, field_i[4]};
        ofs   = 4'd1;
      end
      QAM64: begin
        raw_i = field_i[5:3];
        raw_q = field_i[2:0];
        ofs   = 4'd7;
      end
      default: begin
        raw_i = {1'b0, field_i[5:4]};
        raw_q = {1'b0, field_i[3:2]};
        ofs   = 4'd3;
      end
    endcase
  end

`ifdef QAM_GRAY_EN
  assign n_i = gray2bin(raw_i);
  assign n_q = gray2bin(raw_q);
`else
  assign n_i = raw_i;
  assign n_q = raw_q;
`endif

  // level = 2n - (2^b - 1), always within -7..+7
  always_comb begin
    full_i  = $signed({1'b0, n_i, 1'b0}) - $signed({1'b0, ofs});
    full_q  = $signed({1'b0, n_q, 1'b0}) - $signed({1'b0, ofs});
    lvl_i_o = full_i[3:0];
    lvl_q_o = full_q[3:0];
  end

endmodule

// File: rtl/qam_sym_mapper.sv
// Multi-mode QAM symbol mapper: bytes in over valid/ready, MSB-first k-bit symbols out as
// signed I/Q levels at the sample rate, with SPS-1 zero-stuffed samples per symbol.
// Build option: QAM_GRAY_EN (Gray-coded axis fields, handled in qam_level_map).
module qam_sym_mapper
  import qam_sym_mapper_pkg::*;
#(
  parameter int unsigned MOD_WIDTH = 4,
  parameter int unsigned SPS       = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [1:0]                  mode,
  input  logic [7:0]                  s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic                        sample_en,
  output logic signed [MOD_WIDTH-1:0] m_i,
  output logic signed [MOD_WIDTH-1:0] m_q,
  output logic                        m_valid,
  output logic                        m_zero,
  output logic                        underflow
);

  localparam int unsigned PhW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(SPS - 1);
  localparam logic Allow64 = (MOD_WIDTH >= 4);

  logic [SYM_BUF_BITS-1:0] buf_q, buf_d, buf_sh;
  logic [3:0]              cnt_q, cnt_d, cnt_sh;
  logic [PhW-1:0]          ph_q, ph_d;
  qam_mode_t               mode_q, mode_d;
  logic                    rdy_q;

  logic signed [MOD_WIDTH-1:0] m_i_q, m_i_d, m_q_q, m_q_d;
  logic                        m_valid_q, m_valid_d;
  logic                        m_zero_q, m_zero_d;
  logic                        underflow_q, underflow_d;

  logic [3:0]        k;
  logic              slot, ext, acc;
  logic signed [3:0] lvl_i, lvl_q;

  assign k        = bits_per_sym(mode_q);
  assign slot     = sample_en && (ph_q == '0);
  assign ext      = slot && (cnt_q >= k);
  // No combinational path from s_tvalid; the <=6 limit guarantees room for a full byte.
  assign s_tready = rdy_q && (cnt_q <= 4'd6);
  assign acc      = s_tvalid && s_tready;

  qam_level_map u_level_map (
    .field_i (buf_q[SYM_BUF_BITS-1 -: 6]),
    .mode_i  (mode_q),
    .lvl_i_o (lvl_i),
    .lvl_q_o (lvl_q)
  );

  // Buffer/count/phase/mode next state: extract from the top first, then append below.
  always_comb begin
    buf_sh = ext ? (buf_q << k) : buf_q;
    cnt_sh = ext ? (cnt_q - k) : cnt_q;
    buf_d  = buf_sh;
    cnt_d  = cnt_sh;
    if (acc) begin
      buf_d = buf_sh | (SYM_BUF_BITS'(s_tdata) << (4'd6 - cnt_sh));
      cnt_d = cnt_sh + 4'd8;
    end
    ph_d = ph_q;
    if (sample_en) begin
      ph_d = (ph_q == PhLast) ? '0 : ph_q + PhW'(1);
    end
    // Only switch modes with an empty buffer so residual bits keep their packing mode.
    mode_d = mode_q;
    if (slot && (cnt_q == 4'd0)) begin
      mode_d = decode_mode(mode, Allow64);
    end
  end

  // Output sample next state; data holds between sample ticks, valid/underflow pulse.
  always_comb begin
    m_i_d       = m_i_q;
    m_q_d       = m_q_q;
    m_zero_d    = m_zero_q;
    m_valid_d   = 1'b0;
    underflow_d = 1'b0;
    if (sample_en) begin
      m_valid_d   = 1'b1;
      m_i_d       = ext ? MOD_WIDTH'(lvl_i) : '0;
      m_q_d       = ext ? MOD_WIDTH'(lvl_q) : '0;
      m_zero_d    = !ext;
      underflow_d = slot && !ext;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      ph_q        <= '0;
      mode_q      <= QAM16;
      rdy_q       <= 1'b0;
      m_i_q       <= '0;
      m_q_q       <= '0;
      m_valid_q   <= 1'b0;
      m_zero_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      mode_q      <= mode_d;
      rdy_q       <= 1'b1;
      m_i_q       <= m_i_d;
      m_q_q       <= m_q_d;
      m_valid_q   <= m_valid_d;
      m_zero_q    <= m_zero_d;
      underflow_q <= underflow_d;
    end
  end

  assign m_i       = m_i_q;
  assign m_q       = m_q_q;
  assign m_valid   = m_valid_q;
  assign m_zero    = m_zero_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_qam_sym_mapper.sv
// Directed, table-driven bench for qam_sym_mapper (MOD_WIDTH=4, SPS=4).
// Expectations follow QAM_GRAY_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_qam_sym_mapper;

  localparam int unsigned MW  = 4;
  localparam int unsigned SPS = 4;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic [1:0]           mode;
  logic [7:0]           s_tdata;
  logic                 s_tvalid;
  logic                 s_tready;
  logic                 sample_en;
  logic signed [MW-1:0] m_i, m_q;
  logic                 m_valid, m_zero, underflow;

  always #5 sys_clk = ~sys_clk;

  qam_sym_mapper #(.MOD_WIDTH(MW), .SPS(SPS)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .mode      (mode),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .sample_en (sample_en),
    .m_i       (m_i),
    .m_q       (m_q),
    .m_valid   (m_valid),
    .m_zero    (m_zero),
    .underflow (underflow)
  );

  typedef struct packed {
    logic [1:0]      md;
    logic [1:0]      nb;
    logic [2:0][7:0] b;
    logic [2:0]      ns;
    logic [3:0][7:0] ei;
    logic [3:0][7:0] eq;
  } vec_t;

  vec_t vecs [5];

  int n_total = 0;
  int n_pass  = 0;

  int sym_i[$], sym_q[$];
  int exp_i[$], exp_q[$];
  int n_valid, n_uf, n_zero_bad;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] md, input int nb, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2, input int ns,
                              input int i0, input int q0, input int i1, input int q1,
                              input int i2, input int q2, input int i3, input int q3);
    vec_t v;
    v.md = md;  v.nb = 2'(nb);  v.ns = 3'(ns);
    v.b[0] = b0;  v.b[1] = b1;  v.b[2] = b2;
    v.ei[0] = 8'(i0);  v.eq[0] = 8'(q0);
    v.ei[1] = 8'(i1);  v.eq[1] = 8'(q1);
    v.ei[2] = 8'(i2);  v.eq[2] = 8'(q2);
    v.ei[3] = 8'(i3);  v.eq[3] = 8'(q3);
    return v;
  endfunction

  // 16-QAM reference level for a 2-bit axis field.
  function automatic int lvl2(input logic [1:0] x);
    logic [1:0] n;
`ifdef QAM_GRAY_EN
    n = {x[1], x[1] ^ x[0]};
`else
    n = x;
`endif
    return 2 * int'(n) - 3;
  endfunction

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    s_tvalid  = 1'b0;
    sample_en = 1'b0;
    s_tdata   = '0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (t < 200) begin
      @(negedge sys_clk);
      if (s_tready) break;
      t++;
    end
    if (t >= 200) begin
      n_total++;
      $display("FAIL send_timeout: s_tready stayed 0, expected 1");
    end else begin
      @(posedge sys_clk);
      #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic collect(input int ncyc);
    sym_i.delete();
    sym_q.delete();
    n_valid = 0;  n_uf = 0;  n_zero_bad = 0;
    repeat (ncyc) begin
      @(negedge sys_clk);
      if (m_valid) begin
        n_valid++;
        if (underflow) n_uf++;
        if (m_zero) begin
          if (m_i != 0 || m_q != 0) n_zero_bad++;
        end else begin
          sym_i.push_back(int'(m_i));
          sym_q.push_back(int'(m_q));
          if (underflow) n_zero_bad++;
        end
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    apply_reset();
    mode      = v.md;
    sample_en = 1'b1;
    fork
      begin
        for (int j = 0; j < int'(v.nb); j++) send_byte(v.b[j]);
      end
      collect(80);
    join
    sample_en = 1'b0;
    check($sformatf("v%0d_nsym", idx), sym_i.size(), int'(v.ns));
    for (int j = 0; j < int'(v.ns); j++) begin
      check($sformatf("v%0d_s%0d_i", idx, j), (j < sym_i.size()) ? sym_i[j] : 999,
            int'($signed(v.ei[j])));
      check($sformatf("v%0d_s%0d_q", idx, j), (j < sym_q.size()) ? sym_q[j] : 999,
            int'($signed(v.eq[j])));
    end
    check($sformatf("v%0d_zero_samples", idx), n_zero_bad, 0);
    check($sformatf("v%0d_underflows", idx), n_uf, 20 - int'(v.ns));
    check($sformatf("v%0d_valid_count", idx), n_valid, 80);
  endtask

  initial begin
    int idx, misplaced, nonzero, nozflag, n_acc;

    sys_rst_n = 1'b0;
    mode      = 2'd1;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    sample_en = 1'b0;

    // Reset state.
    #2;
    check("rst_m_i", int'(m_i), 0);
    check("rst_m_q", int'(m_q), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_zero", int'(m_zero), 0);
    check("rst_underflow", int'(underflow), 0);
    check("rst_s_tready", int'(s_tready), 0);

    vecs[0] = mk(2'd0, 1, 8'hB4, 8'h00, 8'h00, 4, 1, -1, 1, 1, -1, 1, -1, -1);
    vecs[1] = mk(2'd0, 1, 8'h1E, 8'h00, 8'h00, 4, -1, -1, -1, 1, 1, 1, 1, -1);
`ifdef QAM_GRAY_EN
    vecs[2] = mk(2'd1, 1, 8'h2D, 8'h00, 8'h00, 2, -3, 3, 1, -1, 0, 0, 0, 0);
    vecs[3] = mk(2'd3, 1, 8'h2D, 8'h00, 8'h00, 2, -3, 3, 1, -1, 0, 0, 0, 0);
    vecs[4] = mk(2'd2, 3, 8'hFF, 8'h00, 8'hFF, 4, 3, 3, 1, -7, -7, -3, 3, 3);
`else
    vecs[2] = mk(2'd1, 1, 8'h2D, 8'h00, 8'h00, 2, -3, 1, 3, -1, 0, 0, 0, 0);
    vecs[3] = mk(2'd3, 1, 8'h2D, 8'h00, 8'h00, 2, -3, 1, 3, -1, 0, 0, 0, 0);
    vecs[4] = mk(2'd2, 3, 8'hFF, 8'h00, 8'hFF, 4, 7, 7, 5, -7, -7, -1, 7, 7);
`endif
    for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

    // Underflow: no input, every 4th sample is an empty symbol slot.
    apply_reset();
    mode      = 2'd1;
    sample_en = 1'b1;
    idx = 0;  n_uf = 0;  misplaced = 0;  nonzero = 0;  nozflag = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (m_valid) begin
        if (underflow) begin
          n_uf++;
          if ((idx % 4) != 0) misplaced++;
        end
        if (m_i != 0 || m_q != 0) nonzero++;
        if (!m_zero) nozflag++;
        idx++;
      end
    end
    sample_en = 1'b0;
    check("uf_count", n_uf, 10);
    check("uf_position", misplaced, 0);
    check("uf_nonzero", nonzero, 0);
    check("uf_m_zero", nozflag, 0);
    check("uf_valid_count", idx, 40);

    // Backpressure: s_tvalid held, scoreboard of accepted bytes.
    apply_reset();
    mode      = 2'd1;
    sample_en = 1'b1;
    exp_i.delete();
    exp_q.delete();
    n_acc = 0;
    fork
      begin
        s_tdata  = 8'h5A;
        s_tvalid = 1'b1;
        repeat (200) begin
          @(negedge sys_clk);
          if (s_tready) begin
            exp_i.push_back(lvl2(s_tdata[7:6]));
            exp_q.push_back(lvl2(s_tdata[5:4]));
            exp_i.push_back(lvl2(s_tdata[3:2]));
            exp_q.push_back(lvl2(s_tdata[1:0]));
            n_acc++;
            @(posedge sys_clk);
            #1;
            s_tdata = s_tdata + 8'd37;
          end
        end
        s_tvalid = 1'b0;
      end
      collect(260);
    join
    sample_en = 1'b0;
    check("bp_rate_ok", int'(n_acc >= 22 && n_acc <= 27), 1);
    check("bp_nsym", sym_i.size(), exp_i.size());
    for (int j = 0; j < exp_i.size(); j++) begin
      check($sformatf("bp_s%0d_i", j), (j < sym_i.size()) ? sym_i[j] : 999, exp_i[j]);
      check($sformatf("bp_s%0d_q", j), (j < sym_q.size()) ? sym_q[j] : 999, exp_q[j]);
    end
    check("bp_zero_samples", n_zero_bad, 0);

    // Reset mid-operation with 6 bits buffered right after the first QPSK symbol.
    apply_reset();
    mode      = 2'd0;
    sample_en = 1'b1;
    send_byte(8'hB4);
    repeat (3) @(posedge sys_clk);
    #3;
    check("mid_pre_valid", int'(m_valid), 1);
    check("mid_pre_m_i", int'(m_i), 1);
    check("mid_pre_m_q", int'(m_q), -1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_m_i", int'(m_i), 0);
    check("mid_rst_m_q", int'(m_q), 0);
    check("mid_rst_m_valid", int'(m_valid), 0);
    check("mid_rst_s_tready", int'(s_tready), 0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    check("mid_rel_ready_first", int'(s_tready), 0);
    @(posedge sys_clk);
    #1;
    check("mid_rel_ready_second", int'(s_tready), 1);
    fork
      send_byte(8'h1E);
      collect(40);
    join
    sample_en = 1'b0;
    check("mid_new_nsym", sym_i.size(), 4);
    check("mid_new_first_i", (sym_i.size() > 0) ? sym_i[0] : 999, -1);
    check("mid_new_first_q", (sym_q.size() > 0) ? sym_q[0] : 999, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
